inertial_interface: RTL and testbench

Front end of the balance datapath. After a power-up wait it configures the inertial sensor over SPI, then reads raw pitch rate and Z acceleration on every sensor data-ready interrupt. For each complete reading it presents signed 16-bit `ptch_rt` and `AZ` with a single-cycle `vld` strobe, which is exactly what the downstream pitch integrator consumes.

---
 rtl/inertial_pkg.sv | 25 ++
 rtl/inertial_interface_spi_mnrch.sv | 94 +++++++++
 rtl/inertial_interface.sv | 165 ++++++++++++++++
 tb/tb_inertial_interface.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inertial_pkg.sv
// Shared types and constants for the inertial sensor front end.
package inertial_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT,
    CFG,
    IDLE,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  localparam int SCLK_DIV_DFLT       = 32;
  localparam int STARTUP_CYCLES_DFLT = 65536;

  // Index 0 is sent first: INT on data-ready, accel 208 Hz +-2 g, gyro 208 Hz, rounding.
  localparam logic [3:0][15:0] CFG_WORDS = {16'h1460, 16'h1150, 16'h1053, 16'h0D02};

  localparam logic [15:0] CMD_RD_PL = 16'hA200;
  localparam logic [15:0] CMD_RD_PH = 16'hA300;
  localparam logic [15:0] CMD_RD_AL = 16'hAC00;
  localparam logic [15:0] CMD_RD_AH = 16'hAD00;

endpackage

// File: rtl/inertial_interface_spi_mnrch.sv
// SPI master: one 16-bit frame per wrt, mode 3 (SCLK idles high), MSB first.
module spi_mnrch
  import inertial_pkg::*;
#(
  parameter int SCLK_DIV = SCLK_DIV_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  // Preset with MSB set so SCLK is high and first falls SCLK_DIV/2 cycles after SS_n.
  localparam logic [DIV_W-1:0] DIV_PRESET = DIV_W'(SCLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_FALL   = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_RISE   = DIV_W'(SCLK_DIV / 2 - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shft_q, shft_d;
  logic             miso_smpl_q, miso_smpl_d;
  logic             ss_n_q, ss_n_d;
  logic             done_q, done_d;

  // Frame sequencing: bit_cnt counts falling edges down; the 17th "fall" ends the frame
  // instead of toggling SCLK. The first fall does not shift so cmd[15] stays on MOSI.
  always_comb begin
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shft_d      = shft_q;
    miso_smpl_d = miso_smpl_q;
    ss_n_d      = ss_n_q;
    done_d      = 1'b0;
    if (ss_n_q) begin
      div_d = DIV_PRESET;
      if (wrt) begin
        ss_n_d    = 1'b0;
        bit_cnt_d = 5'd16;
        shft_d    = cmd;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
      if (div_q == DIV_RISE) begin
        miso_smpl_d = MISO;
      end
      if (div_q == DIV_FALL) begin
        if (bit_cnt_q == 5'd0) begin
          ss_n_d = 1'b1;
          done_d = 1'b1;
          div_d  = DIV_PRESET;
          shft_d = {shft_q[14:0], miso_smpl_q};
        end else begin
          bit_cnt_d = bit_cnt_q - 5'd1;
          if (bit_cnt_q != 5'd16) begin
            shft_d = {shft_q[14:0], miso_smpl_q};
          end
        end
      end
    end
  end

  // SPI state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= DIV_PRESET;
      bit_cnt_q   <= 5'd0;
      shft_q      <= 16'h0000;
      miso_smpl_q <= 1'b0;
      ss_n_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      shft_q      <= shft_d;
      miso_smpl_q <= miso_smpl_d;
      ss_n_q      <= ss_n_d;
      done_q      <= done_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = div_q[DIV_W-1];
  assign MOSI    = ~ss_n_q & shft_q[15];
  assign done    = done_q;
  assign rd_data = shft_q;

endmodule

// File: rtl/inertial_interface.sv
// Inertial sensor front end: startup wait, sensor config, then pitch-rate/Z-accel reads per INT.
//
// state     | meaning
// ----------+---------------------------------------------------
// INIT_WAIT | power-up delay before touching the sensor
// CFG       | writing the four configuration words in order
// IDLE      | waiting for synchronized data-ready
// RD_PL     | reading pitch rate low byte
// RD_PH     | reading pitch rate high byte
// RD_AL     | reading Z accel low byte
// RD_AH     | reading Z accel high byte, then publish with vld
module inertial_interface
  import inertial_pkg::*;
#(
  parameter int SCLK_DIV       = SCLK_DIV_DFLT,
  parameter int STARTUP_CYCLES = STARTUP_CYCLES_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               INT,
  input  logic               MISO,
  output logic               SS_n,
  output logic               SCLK,
  output logic               MOSI,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] AZ,
  output logic               vld
);

  localparam int STRT_W = $clog2(STARTUP_CYCLES + 1);

  state_t              state_q, state_d;
  logic [STRT_W-1:0]   strt_cnt_q, strt_cnt_d;
  logic [1:0]          cfg_idx_q, cfg_idx_d;
  logic                issued_q, issued_d;
  logic                int_ff1_q, int_ff1_d, int_ff2_q, int_ff2_d;
  logic [7:0]          pl_q, pl_d, ph_q, ph_d, al_q, al_d;
  logic signed [15:0]  ptch_rt_q, ptch_rt_d, az_q, az_d;
  logic                vld_q, vld_d;

  logic        wrt, done, xfer_done;
  logic [15:0] cmd, rd_data;
  logic        rd_hi_unused;

  assign rd_hi_unused = ^rd_data[15:8];
  assign xfer_done    = issued_q & done;

  // Sequencer: every SPI state fires wrt once on entry and advances on its done.
  always_comb begin
    state_d    = state_q;
    strt_cnt_d = strt_cnt_q;
    cfg_idx_d  = cfg_idx_q;
    issued_d   = issued_q;
    int_ff1_d  = INT;
    int_ff2_d  = int_ff1_q;
    pl_d       = pl_q;
    ph_d       = ph_q;
    al_d       = al_q;
    ptch_rt_d  = ptch_rt_q;
    az_d       = az_q;
    vld_d      = 1'b0;
    wrt        = 1'b0;
    cmd        = 16'h0000;
    case (state_q)
      INIT_WAIT: begin
        if (strt_cnt_q == '0) state_d = CFG;
        else                  strt_cnt_d = strt_cnt_q - STRT_W'(1);
      end
      CFG: begin
        cmd = CFG_WORDS[cfg_idx_q];
        if (xfer_done) begin
          cfg_idx_d = cfg_idx_q + 2'd1;
          if (cfg_idx_q == 2'd3) state_d = IDLE;
        end
      end
      IDLE: begin
        if (int_ff2_q) state_d = RD_PL;
      end
      RD_PL: begin
        cmd = CMD_RD_PL;
        if (xfer_done) begin
          pl_d    = rd_data[7:0];
          state_d = RD_PH;
        end
      end
      RD_PH: begin
        cmd = CMD_RD_PH;
        if (xfer_done) begin
          ph_d    = rd_data[7:0];
          state_d = RD_AL;
        end
      end
      RD_AL: begin
        cmd = CMD_RD_AL;
        if (xfer_done) begin
          al_d    = rd_data[7:0];
          state_d = RD_AH;
        end
      end
      RD_AH: begin
        cmd = CMD_RD_AH;
        if (xfer_done) begin
          ptch_rt_d = {ph_q, pl_q};
          az_d      = {rd_data[7:0], al_q};
          vld_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = INIT_WAIT;
    endcase
    if (state_q inside {CFG, RD_PL, RD_PH, RD_AL, RD_AH}) begin
      wrt      = ~issued_q;
      issued_d = ~xfer_done;
    end
  end

  // State, counters, synchronizer, holding and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_WAIT;
      strt_cnt_q <= STRT_W'(STARTUP_CYCLES - 1);
      cfg_idx_q  <= 2'd0;
      issued_q   <= 1'b0;
      int_ff1_q  <= 1'b0;
      int_ff2_q  <= 1'b0;
      pl_q       <= 8'h00;
      ph_q       <= 8'h00;
      al_q       <= 8'h00;
      ptch_rt_q  <= '0;
      az_q       <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      strt_cnt_q <= strt_cnt_d;
      cfg_idx_q  <= cfg_idx_d;
      issued_q   <= issued_d;
      int_ff1_q  <= int_ff1_d;
      int_ff2_q  <= int_ff2_d;
      pl_q       <= pl_d;
      ph_q       <= ph_d;
      al_q       <= al_d;
      ptch_rt_q  <= ptch_rt_d;
      az_q       <= az_d;
      vld_q      <= vld_d;
    end
  end

  spi_mnrch #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  assign ptch_rt = ptch_rt_q;
  assign AZ      = az_q;
  assign vld     = vld_q;

endmodule

// File: tb/tb_inertial_interface.sv
// Bench for inertial_interface with a behavioural SPI sensor and frame/SCLK monitor.
module tb_inertial_interface;

  localparam int DIV       = 8;
  localparam int STRT      = 64;
  localparam int FRAME_LOW = 16 * DIV + DIV / 2;
  localparam int FRAME_BUD = 4 * (FRAME_LOW + 6) + 40;

  localparam logic [15:0] CFG_EXP [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [15:0] RD_EXP  [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic INT = 1'b0;
  logic MISO = 1'b0;
  logic SS_n, SCLK, MOSI, vld;
  logic signed [15:0] ptch_rt, AZ;

  inertial_interface #(.SCLK_DIV(DIV), .STARTUP_CYCLES(STRT)) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .ptch_rt (ptch_rt),
    .AZ      (AZ),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sensor register contents returned for the four read addresses.
  logic [7:0] reg_pl = 8'h00, reg_ph = 8'h00, reg_al = 8'h00, reg_ah = 8'h00;

  function automatic logic [7:0] sensor_reg(input logic [7:0] addr);
    case (addr)
      8'hA2:   return reg_pl;
      8'hA3:   return reg_ph;
      8'hAC:   return reg_al;
      8'hAD:   return reg_ah;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor / sensor model, everything sampled on the falling clk edge.
  logic [15:0] frames[$];
  int cyc = 0, rises = 0, falls = 0, low_cyc = 0, last_fall = 0;
  int period_err = 0, mosi_err = 0, edge_err = 0, len_err = 0, idle_err = 0, out_err = 0;
  int vld_cnt = 0;
  logic [15:0] mosi_w = 16'h0;
  logic [7:0]  resp = 8'h00;
  logic prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
  logic [15:0] prev_pt = 16'h0, prev_az = 16'h0;

  always @(negedge clk) begin
    cyc++;
    if (!SS_n && prev_ss) begin
      rises = 0; falls = 0; low_cyc = 0; mosi_w = 16'h0; resp = 8'h00; MISO = 1'b0;
    end
    if (!SS_n) begin
      low_cyc++;
      if (prev_sclk && !SCLK) begin
        if (falls > 0 && (cyc - last_fall) != DIV) period_err++;
        last_fall = cyc;
        if (falls >= 8) MISO = resp[15 - falls];
        else            MISO = 1'b0;
        falls++;
      end
      if (!prev_sclk && SCLK) begin
        if (MOSI != prev_mosi) mosi_err++;
        mosi_w = {mosi_w[14:0], MOSI};
        rises++;
        if (rises == 8) resp = sensor_reg(mosi_w[7:0]);
      end else if (!prev_ss && MOSI != prev_mosi && !(prev_sclk && !SCLK)) begin
        mosi_err++;
      end
    end else begin
      if (!SCLK) idle_err++;
      if (!prev_ss && !rst) begin
        frames.push_back(mosi_w);
        if (rises != 16 || falls != 16) edge_err++;
        if (low_cyc != FRAME_LOW) len_err++;
      end
    end
    if (vld) vld_cnt++;
    if (!rst && !vld && (ptch_rt != prev_pt || AZ != prev_az)) out_err++;
    prev_pt   = ptch_rt;
    prev_az   = AZ;
    prev_ss   = SS_n;
    prev_sclk = SCLK;
    prev_mosi = MOSI;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_int(input int n);
    INT = 1'b1;
    wait_cycles(n);
    INT = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frames.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, frames.size(), n);
  endtask

  task automatic check_words(input string tag, input logic [15:0] exp [4]);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s_w%0d", tag, i), (i < frames.size()) ? frames[i] : 16'hDEAD, exp[i]);
  endtask

  task automatic startup(input string tag);
    int k = 0;
    frames.delete();
    @(negedge clk);
    rst = 1'b0;
    while (SS_n && k < 4 * STRT) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_wait"}, k, STRT + 1);
    wait_frames(4, FRAME_BUD, {tag, "_nfrm"});
    check_words(tag, CFG_EXP);
  endtask

  task automatic do_read(input logic [7:0] pl, ph, al, ah, input logic [15:0] exp_pt, exp_az,
                         input string tag);
    int k = 0;
    reg_pl = pl; reg_ph = ph; reg_al = al; reg_ah = ah;
    frames.delete();
    vld_cnt = 0;
    pulse_int(3);
    while (vld_cnt == 0 && k < FRAME_BUD) begin
      @(negedge clk);
      k++;
    end
    wait_cycles(40);
    check_val({tag, "_nfrm"}, frames.size(), 4);
    check_words(tag, RD_EXP);
    check_val({tag, "_vld"}, vld_cnt, 1);
    check_val({tag, "_pt"}, $unsigned(ptch_rt), exp_pt);
    check_val({tag, "_az"}, $unsigned(AZ), exp_az);
  endtask

  initial begin
    int k;
    wait_cycles(3);
    check_val("rst_ss", SS_n, 1'b1);
    check_val("rst_sclk", SCLK, 1'b1);
    check_val("rst_mosi", MOSI, 1'b0);
    check_val("rst_vld", vld, 1'b0);
    check_val("rst_pt", $unsigned(ptch_rt), 16'h0000);
    check_val("rst_az", $unsigned(AZ), 16'h0000);

    startup("cfg");

    do_read(8'h34, 8'h12, 8'h78, 8'h56, 16'h1234, 16'h5678, "rd1");
    do_read(8'hFF, 8'hFF, 8'h00, 8'h80, 16'hFFFF, 16'h8000, "rd2");
    check_val("rd2_pt_neg1", ptch_rt == -1, 1'b1);
    check_val("rd2_az_min", AZ == -32768, 1'b1);

    // INT pulsed again while the RD_PH frame is in flight.
    reg_pl = 8'h9A; reg_ph = 8'h78; reg_al = 8'h21; reg_ah = 8'h43;
    frames.delete();
    vld_cnt = 0;
    pulse_int(3);
    k = 0;
    while (!(frames.size() == 1 && !SS_n) && k < FRAME_BUD) begin
      @(negedge clk);
      k++;
    end
    check_val("tgl_in_ph", frames.size(), 1);
    wait_cycles(30);
    pulse_int(3);
    wait_cycles(1000);
    check_val("tgl_nfrm", frames.size(), 4);
    check_val("tgl_vld", vld_cnt, 1);
    check_val("tgl_pt", $unsigned(ptch_rt), 16'h789A);
    check_val("tgl_az", $unsigned(AZ), 16'h4321);

    // INT held high: reads run back to back.
    reg_pl = 8'h01; reg_ph = 8'h02; reg_al = 8'h03; reg_ah = 8'h04;
    frames.delete();
    vld_cnt = 0;
    INT = 1'b1;
    k = 0;
    while (vld_cnt < 3 && k < 4 * FRAME_BUD) begin
      @(negedge clk);
      k++;
    end
    INT = 1'b0;
    wait_cycles(800);
    check_val("hold_vld3", vld_cnt >= 3, 1'b1);
    check_val("hold_ratio", frames.size(), 4 * vld_cnt);
    check_val("hold_pt", $unsigned(ptch_rt), 16'h0201);
    check_val("hold_az", $unsigned(AZ), 16'h0403);

    // Reset in the middle of the RD_AL frame.
    reg_pl = 8'hAA; reg_ph = 8'hBB; reg_al = 8'hCC; reg_ah = 8'hDD;
    frames.delete();
    vld_cnt = 0;
    pulse_int(3);
    k = 0;
    while (!(frames.size() == 2 && !SS_n) && k < FRAME_BUD) begin
      @(negedge clk);
      k++;
    end
    check_val("mid_in_al", frames.size(), 2);
    wait_cycles(30);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_ss", SS_n, 1'b1);
    check_val("mid_sclk", SCLK, 1'b1);
    check_val("mid_mosi", MOSI, 1'b0);
    check_val("mid_vld", vld, 1'b0);
    check_val("mid_pt", $unsigned(ptch_rt), 16'h0000);
    check_val("mid_az", $unsigned(AZ), 16'h0000);
    wait_cycles(3);
    startup("recfg");
    check_val("mid_novld", vld_cnt, 0);
    check_val("mid_pt_hold", $unsigned(ptch_rt), 16'h0000);
    do_read(8'hEF, 8'hBE, 8'h0D, 8'hF0, 16'hBEEF, 16'hF00D, "rd3");

    check_val("sclk_period", period_err, 0);
    check_val("mosi_stable", mosi_err, 0);
    check_val("sclk_edges", edge_err, 0);
    check_val("ss_low_len", len_err, 0);
    check_val("sclk_idle", idle_err, 0);
    check_val("out_hold", out_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
